// File: rtl/npc_pkg.sv
// Shared widths and index type for the operand-fetch stage and its scoreboard.
package npc_pkg;

   localparam int XLEN   = 64;
   localparam int NREG   = 32;
   localparam int ADDR_W = $clog2(NREG);

   typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Per-register pending-write scoreboard; flags RAW on both sources and WAW on rd.
module opfetch_scoreboard
   import npc_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  reg_idx_t rs1,
   input  reg_idx_t rs2,
   input  reg_idx_t rd,
   input  logic     use_rs1,
   input  logic     use_rs2,
   input  logic     rd_wen,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     wb_valid,
   input  reg_idx_t wb_rd,
   input  logic     kill_en,
   input  reg_idx_t kill_idx,
   output logic     raw1,
   output logic     raw2,
   output logic     waw
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   logic wb_hit1;
   logic wb_hit2;
   logic wb_hitd;

   assign wb_hit1 = wb_valid && (wb_rd == rs1);
   assign wb_hit2 = wb_valid && (wb_rd == rs2);
   assign wb_hitd = wb_valid && (wb_rd == rd);

   assign raw1 = use_rs1 && (rs1 != '0)
              && pending[rs1] && !wb_hit1;
   assign raw2 = use_rs2 && (rs2 != '0)
              && pending[rs2] && !wb_hit2;
   assign waw  = rd_wen && (rd != '0)
              && pending[rd] && !wb_hitd;

   // Clears first so a same-index set in the same cycle wins.
   always_comb begin
      pending_nxt = pending;
      if (wb_valid) pending_nxt[wb_rd] = 1'b0;
      if (kill_en) pending_nxt[kill_idx] = 1'b0;
      if (set_en) pending_nxt[set_idx] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pending <= '0;
      else pending <= pending_nxt;
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: RF read, writeback bypass, hazard stall, one output slot.
// Optional stall/issue counters built when OPFETCH_STALL_STATS_EN is defined.
module operand_fetch
   import npc_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   input  reg_idx_t        in_rs1,
   input  reg_idx_t        in_rs2,
   input  logic            in_use_rs1,
   input  logic            in_use_rs2,
   input  reg_idx_t        in_rd,
   input  logic            in_rd_wen,
   output reg_idx_t        rf_raddr1,
   output reg_idx_t        rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_valid,
   input  reg_idx_t        wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_src1,
   output logic [XLEN-1:0] out_src2,
   output reg_idx_t        out_rd,
   output logic            out_rd_wen
`ifdef OPFETCH_STALL_STATS_EN
   ,
   output logic [63:0]     stat_stall_cycles,
   output logic [63:0]     stat_issued
`endif
);

   logic raw1;
   logic raw2;
   logic waw;
   logic stall;
   logic accept;
   logic kill_en;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;

   function automatic logic [XLEN-1:0] pick(
      input reg_idx_t        rs,
      input logic [XLEN-1:0] rf,
      input logic            wv,
      input reg_idx_t        wr,
      input logic [XLEN-1:0] wd
   );
      if (rs == '0) return '0;
      if (wv && (wr == rs)) return wd;
      return rf;
   endfunction

   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

   assign stall    = raw1 | raw2 | waw;
   assign in_ready = !stall && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign kill_en  = flush && out_valid && out_rd_wen
                  && (out_rd != '0);

   assign src1 = pick(in_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
   assign src2 = pick(in_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);

   opfetch_scoreboard u_sb (
      .clock    (clock),
      .reset_n  (reset_n),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .rd       (in_rd),
      .use_rs1  (in_use_rs1),
      .use_rs2  (in_use_rs2),
      .rd_wen   (in_rd_wen),
      .set_en   (accept && in_rd_wen && (in_rd != '0)),
      .set_idx  (in_rd),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .kill_en  (kill_en),
      .kill_idx (out_rd),
      .raw1     (raw1),
      .raw2     (raw2),
      .waw      (waw)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_pc     <= '0;
         out_inst   <= '0;
         out_src1   <= '0;
         out_src2   <= '0;
         out_rd     <= '0;
         out_rd_wen <= 1'b0;
      end else if (accept) begin
         out_pc     <= in_pc;
         out_inst   <= in_inst;
         out_src1   <= src1;
         out_src2   <= src2;
         out_rd     <= in_rd;
         out_rd_wen <= in_rd_wen;
      end
   end

`ifdef OPFETCH_STALL_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_stall_cycles <= '0;
         stat_issued       <= '0;
      end else begin
         if (in_valid && stall)
            stat_stall_cycles <= stat_stall_cycles + 64'd1;
         if (accept)
            stat_issued <= stat_issued + 64'd1;
      end
   end
`endif

endmodule
